// File: rtl/instr_pkg.sv
// Shared instruction-word layout: field positions and parameter legality rules,
// used by both the field decoder and the queue control.
package instr_pkg;

  localparam int DEF_OP_BITS  = 4;
  localparam int DEF_REG_BITS = 4;
  localparam int DEF_WIDTH    = 2 * DEF_OP_BITS + 2 * DEF_REG_BITS;
  localparam int DEF_IMM_BITS = DEF_OP_BITS + DEF_REG_BITS;
  localparam int DEF_DEPTH    = 4;

  // Layout from MSB down: op_code | A index | ext_op_code | B index.
  // The immediate overlays the low (ext_op_code | B index) bits.
  function automatic int op_lsb(input int op_bits, input int reg_bits);
    return op_bits + 2 * reg_bits;
  endfunction

  function automatic int a_lsb(input int op_bits, input int reg_bits);
    return op_bits + reg_bits;
  endfunction

  function automatic int ext_lsb(input int reg_bits);
    return reg_bits;
  endfunction

  localparam int B_LSB   = 0;
  localparam int IMM_LSB = 0;

  function automatic bit layout_ok(input int width, input int op_bits,
                                   input int reg_bits, input int imm_bits);
    return (width == 2 * op_bits + 2 * reg_bits) &&
           (imm_bits == op_bits + reg_bits);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational split of one instruction word into its fields, plus the
// immediate sign-extended back to the full word width.
module instr_field_decode
  import instr_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int OP_BITS  = DEF_OP_BITS,
  parameter int REG_BITS = DEF_REG_BITS,
  parameter int IMM_BITS = DEF_IMM_BITS
) (
  input  logic [WIDTH-1:0]    word,
  output logic [OP_BITS-1:0]  op_code,
  output logic [REG_BITS-1:0] A_index_out,
  output logic [OP_BITS-1:0]  ext_op_code,
  output logic [REG_BITS-1:0] B_index_out,
  output logic [IMM_BITS-1:0] immediate_value,
  output logic [WIDTH-1:0]    imm_sext
);

  localparam int OP_LSB  = op_lsb(OP_BITS, REG_BITS);
  localparam int A_LSB   = a_lsb(OP_BITS, REG_BITS);
  localparam int EXT_LSB = ext_lsb(REG_BITS);

  assign op_code         = word[OP_LSB  +: OP_BITS];
  assign A_index_out     = word[A_LSB   +: REG_BITS];
  assign ext_op_code     = word[EXT_LSB +: OP_BITS];
  assign B_index_out     = word[B_LSB   +: REG_BITS];
  assign immediate_value = word[IMM_LSB +: IMM_BITS];
  assign imm_sext        = {{(WIDTH - IMM_BITS){immediate_value[IMM_BITS-1]}},
                            immediate_value};

endmodule

// File: rtl/instruction_queue.sv
// Small register-array instruction FIFO; the head entry is decoded into its
// fields combinationally from registered storage only.
module instruction_queue
  import instr_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int OP_BITS  = DEF_OP_BITS,
  parameter int REG_BITS = DEF_REG_BITS,
  parameter int IMM_BITS = DEF_IMM_BITS,
  parameter int DEPTH    = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_instr,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OP_BITS-1:0]         op_code,
  output logic [OP_BITS-1:0]         ext_op_code,
  output logic [REG_BITS-1:0]        A_index_out,
  output logic [REG_BITS-1:0]        B_index_out,
  output logic [IMM_BITS-1:0]        immediate_value,
  output logic [WIDTH-1:0]           imm_sext,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (!layout_ok(WIDTH, OP_BITS, REG_BITS, IMM_BITS)) begin : g_bad_layout
    $error("instruction_queue: WIDTH must be 2*OP_BITS+2*REG_BITS and IMM_BITS OP_BITS+REG_BITS");
  end
  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("instruction_queue: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_word;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready depends only on occupancy (never on out_ready), and
  // out_valid is high exactly while at least one entry is stored.
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      // Flush wins over any handshake in the same cycle; stale storage is
      // harmless because the head is masked while empty.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_instr;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Forcing the decoder input to zero when empty makes every field read 0.
  assign head_word = out_valid ? mem[rd_ptr] : '0;

  instr_field_decode #(
    .WIDTH   (WIDTH),
    .OP_BITS (OP_BITS),
    .REG_BITS(REG_BITS),
    .IMM_BITS(IMM_BITS)
  ) u_decode (
    .word           (head_word),
    .op_code        (op_code),
    .A_index_out    (A_index_out),
    .ext_op_code    (ext_op_code),
    .B_index_out    (B_index_out),
    .immediate_value(immediate_value),
    .imm_sext       (imm_sext)
  );

endmodule

// File: tb/tb_instruction_queue.sv
// Randomized scoreboard bench for instruction_queue: a queue-based reference
// model predicts occupancy and head fields, checked every cycle on the falling edge.
module tb_instruction_queue;

  localparam int W     = 16;
  localparam int OPB   = 4;
  localparam int REGB  = 4;
  localparam int IMMB  = 8;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic [W-1:0]    in_instr = '0;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [OPB-1:0]  op_code;
  logic [OPB-1:0]  ext_op_code;
  logic [REGB-1:0] A_index_out;
  logic [REGB-1:0] B_index_out;
  logic [IMMB-1:0] immediate_value;
  logic [W-1:0]    imm_sext;
  logic [2:0]      count;

  logic [W-1:0] exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  instruction_queue dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_instr       (in_instr),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .op_code        (op_code),
    .ext_op_code    (ext_op_code),
    .A_index_out    (A_index_out),
    .B_index_out    (B_index_out),
    .immediate_value(immediate_value),
    .imm_sext       (imm_sext),
    .count          (count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference field arithmetic straight from the word layout.
  function automatic int f_op(input int w);  return (w / 4096) % 16; endfunction
  function automatic int f_a(input int w);   return (w / 256) % 16;  endfunction
  function automatic int f_ext(input int w); return (w / 16) % 16;   endfunction
  function automatic int f_b(input int w);   return w % 16;          endfunction
  function automatic int f_imm(input int w); return w % 256;         endfunction
  function automatic int f_sext(input int w);
    int imm;
    imm = w % 256;
    return (imm >= 128) ? (imm + 65536 - 256) : imm;
  endfunction

  task automatic chk_head(input string tag, input int w);
    chk({tag, "_op"},   32'(op_code),         32'(f_op(w)));
    chk({tag, "_a"},    32'(A_index_out),     32'(f_a(w)));
    chk({tag, "_ext"},  32'(ext_op_code),     32'(f_ext(w)));
    chk({tag, "_b"},    32'(B_index_out),     32'(f_b(w)));
    chk({tag, "_imm"},  32'(immediate_value), 32'(f_imm(w)));
    chk({tag, "_sext"}, 32'(imm_sext),        32'(f_sext(w)));
  endtask

  // Scoreboard monitor: compares DUT state against the model, then applies
  // the handshake the upcoming edge will perform.
  always @(negedge clk) begin
    int sz;
    logic [W-1:0] w;
    if (reset) begin
      exp_q.delete();
    end else begin
      sz = exp_q.size();
      chk("mon_count", 32'(count), 32'(sz));
      chk("mon_out_valid", 32'(out_valid), 32'(sz != 0));
      chk("mon_in_ready", 32'(in_ready), 32'(sz < DEPTH));
      if (sz != 0) begin
        w = exp_q[0];
        chk_head("mon_head", int'(w));
      end else begin
        chk_head("mon_empty", 0);
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_ready && sz > 0) void'(exp_q.pop_front());
        if (in_valid && sz < DEPTH) exp_q.push_back(in_instr);
      end
    end
  end

  // Driver tasks: inputs change 1 time unit after a rising edge.
  task automatic step(input logic v, input logic [W-1:0] w, input logic r, input logic f);
    in_valid  = v;
    in_instr  = w;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(); step(1'b0, '0, 1'b0, 1'b0); endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) step(1'b1, W'($urandom), 1'b0, 1'b0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_count"},     32'(count),     32'(0));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_in_ready"},  32'(in_ready),  32'(1));
    chk_head(tag, 0);
  endtask

  initial begin
    logic [W-1:0] w;
    // Reset state
    #2;
    chk_zero_outputs("reset_init");
    @(posedge clk); #1;
    reset = 1'b0;
    idle();

    // First word appears immediately after its edge
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    chk("w1234_count", 32'(count), 32'(1));
    chk("w1234_out_valid", 32'(out_valid), 32'(1));
    chk_head("w1234", 32'h1234);
    step(1'b0, '0, 1'b0, 1'b1);

    // Negative immediate
    step(1'b1, 16'h5A80, 1'b0, 1'b0);
    chk("w5a80_imm", 32'(immediate_value), 32'h80);
    chk("w5a80_sext", 32'(imm_sext), 32'hFF80);
    chk("w5a80_op", 32'(op_code), 32'h5);
    chk("w5a80_a", 32'(A_index_out), 32'hA);
    step(1'b0, '0, 1'b0, 1'b1);

    // Fill, refused fifth offer, drain
    push_words(4);
    chk("full_count", 32'(count), 32'(4));
    chk("full_in_ready", 32'(in_ready), 32'(0));
    step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    chk("full_5th_count", 32'(count), 32'(4));
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk_zero_outputs("drained");

    // Steady push+pop at count=2 across pointer wrap
    push_words(2);
    for (int i = 0; i < 10; i++) step(1'b1, W'($urandom), 1'b1, 1'b0);
    chk("pp_count", 32'(count), 32'(2));
    for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Flush overrides a same-cycle push
    push_words(3);
    step(1'b1, 16'hBEEF, 1'b0, 1'b1);
    chk("flush_count", 32'(count), 32'(0));
    chk("flush_out_valid", 32'(out_valid), 32'(0));
    step(1'b1, 16'h7E01, 1'b0, 1'b0);
    chk_head("post_flush", 32'h7E01);
    step(1'b0, '0, 1'b0, 1'b1);

    // Asynchronous reset between edges
    push_words(3);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_zero_outputs("async_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    w = W'($urandom);
    step(1'b1, w, 1'b0, 1'b0);
    chk_head("post_reset", int'(w));
    step(1'b0, '0, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 19) == 0));
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_queue.md
INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 16, instruction word width in bits.
REQ-002 SHALL have parameter OP_BITS, default 4, width of op_code and ext_op_code.
REQ-003 SHALL have parameter REG_BITS, default 4, width of each register index.
REQ-004 SHALL have parameter IMM_BITS, default 8, immediate field width.
REQ-005 SHALL have parameter DEPTH, default 4, entry count; power of two, >= 2.
REQ-006 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-007 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-008 SHALL have port flush, input, 1, synchronous discard of all entries.
REQ-009 SHALL have port in_valid, input, 1, producer offers in_instr.
REQ-010 SHALL have port in_instr, input, WIDTH, instruction word.
REQ-011 SHALL have port in_ready, output, 1, queue accepts a word this cycle.
REQ-012 SHALL have port out_valid, output, 1, head entry present.
REQ-013 SHALL have port out_ready, input, 1, consumer takes head this cycle.
REQ-014 SHALL have ports op_code and ext_op_code, output, OP_BITS each, head fields.
REQ-015 SHALL have ports A_index_out and B_index_out, output, REG_BITS each, head register indices.
REQ-016 SHALL have port immediate_value, output, IMM_BITS, head immediate.
REQ-017 SHALL have port imm_sext, output, WIDTH, immediate_value sign-extended to WIDTH.
REQ-018 SHALL have port count, output, clog2(DEPTH)+1, occupied entries.

Function
REQ-019 Field map of a word w SHALL be: op_code = top OP_BITS; A_index_out = next REG_BITS; ext_op_code = next OP_BITS; B_index_out = low REG_BITS; immediate_value = low IMM_BITS (16-bit default: [15:12],[11:8],[7:4],[3:0],[7:0]).
REQ-020 Parameters SHALL satisfy WIDTH = 2*OP_BITS + 2*REG_BITS and IMM_BITS = OP_BITS + REG_BITS; violation SHALL fail elaboration.
REQ-021 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-022 in_ready SHALL equal (count < DEPTH), independent of out_ready (no full-time pass-through).
REQ-023 out_valid SHALL equal (count != 0).
REQ-024 Latency: a word pushed at edge N SHALL appear as head, with out_valid high, immediately after edge N when queue was empty.
REQ-025 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; entries SHALL emerge in push order.
REQ-027 flush SHALL set count and both pointers to 0 at the next edge and SHALL override a same-cycle push or pop (pushed word dropped).
REQ-028 When out_valid is 0, all field outputs and imm_sext SHALL be 0.
REQ-029 Field outputs SHALL be combinational from the registered head entry only; no path from in_instr to any field output.
REQ-030 Push while full or pop while empty SHALL be impossible by handshake and SHALL leave state unchanged.

Reset
REQ-031 Asserting reset SHALL immediately clear count, pointers and all storage to 0; in_ready=1, out_valid=0, all fields 0.
REQ-032 Reset asserted mid-transfer SHALL discard all entries; first accepted word after release SHALL be the next head.

Structure
REQ-033 Field bit positions/widths as constants SHALL live in shared package instr_pkg, reused by decode and control.
REQ-034 Field extraction plus sign extension SHALL be sub-module instr_field_decode (combinational, one word in, fields out).
REQ-035 Storage SHALL be a DEPTH x WIDTH register array with separate pointers and count register; no inferred RAM.

Verification
REQ-036 Reset, push 0x1234 with out_ready=0 -> next cycle out_valid=1, op=1, A=2, ext=3, B=4, imm=0x34, imm_sext=0x0034, count=1.
REQ-037 Push 0x5A80 -> immediate_value=0x80, imm_sext=0xFF80, op=5, A=0xA.
REQ-038 Push 4 words with out_ready=0 -> count=4, in_ready=0; 5th offer ignored; drain returns 4 words in order, then out_valid=0, fields 0.
REQ-039 Count=2, push and pop same cycle, repeated 10 cycles across pointer wrap -> count stays 2, output order matches input order.
REQ-040 Count=3, flush with in_valid=1 same cycle -> next cycle count=0, out_valid=0, offered word absent.
REQ-041 Reset asserted between edges while count=3 -> outputs zero without a clock edge; after release, first pushed word is head.
